// File: rtl/drum_sample_tap_if.sv
// Node-stream and audio-sample handshake bundle for drum_sample_tap.
// The slave side is the tap block; the master side is the solver plus the audio consumer.
interface drum_sample_tap_if;
    logic        node_valid;
    logic [5:0]  node_row;
    logic [17:0] node_amp;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output node_valid, node_row, node_amp, sample_ready,
        input  sample_data, sample_valid
    );

    modport slave (
        input  node_valid, node_row, node_amp, sample_ready,
        output sample_data, sample_valid
    );
endinterface

// File: rtl/drum_sample_tap.sv
// Taps one row of the drum column solver's amplitude stream per time step,
// scales it to a 16-bit audio sample and queues it for the audio output path.
module drum_sample_tap #(
    parameter logic [5:0] NUM_ROW    = 6'd33,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [5:0] DEF_TAP    = 6'd16
) (
    input  logic              clk,
    input  logic              rst,
    drum_sample_tap_if.slave  bus,
    input  logic [5:0]        tap_row,
    input  logic [2:0]        gain_shift,
    output logic              step_done,
    output logic [4:0]        fifo_level,
    output logic [15:0]       overflow_count,
    output logic [15:0]       seq_err_count
);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [5:0] LAST_ROW = NUM_ROW - 6'd1;
    localparam logic [4:0] DEPTH    = 5'(FIFO_DEPTH);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t          state, state_next;
    logic [5:0]      expected_row, tap_r, tap_new, tap_cur;
    logic            hit;
    logic [15:0]     capture;
    logic            in_seq, seq_err, tap_hit, last_row, push_req;
    logic [15:0]     push_data;

    logic [24:0]     amp_ext, amp_shift;
    logic [15:0]     scaled;
    logic            unused_low_bits;

    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [15:0]     last_data;
    logic            pop, full, do_push, drop;

    // Shift in a wide signed copy so saturation only has to look at the spilled-over bits.
    assign amp_ext         = {{7{bus.node_amp[17]}}, bus.node_amp};
    assign amp_shift       = amp_ext << gain_shift;
    assign scaled          = (amp_shift[24:17] == {8{amp_shift[24]}}) ? amp_shift[17:2]
                           : (amp_shift[24] ? 16'h8000 : 16'h7FFF);
    assign unused_low_bits = ^amp_shift[1:0];

    assign tap_new = (tap_row >= NUM_ROW) ? DEF_TAP : tap_row;
    assign tap_cur = (bus.node_row == 6'd0) ? tap_new : tap_r;

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_seq     = 1'b0;
        seq_err    = 1'b0;
        case (state)
            HUNT: begin
                if (bus.node_valid && bus.node_row == 6'd0) begin
                    in_seq     = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.node_valid) begin
                    if (bus.node_row == expected_row) begin
                        in_seq = 1'b1;
                    end else begin
                        seq_err    = 1'b1;
                        state_next = HUNT;
                    end
                end
            end
            default: state_next = HUNT;
        endcase
        tap_hit   = in_seq && (bus.node_row == tap_cur);
        last_row  = in_seq && (bus.node_row == LAST_ROW);
        push_req  = last_row && (hit || tap_hit);
        push_data = tap_hit ? scaled : capture;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expected_row  <= 6'd0;
            tap_r         <= DEF_TAP;
            hit           <= 1'b0;
            capture       <= 16'd0;
            step_done     <= 1'b0;
            seq_err_count <= 16'd0;
        end else begin
            step_done <= last_row;
            if (in_seq && bus.node_row == 6'd0) tap_r <= tap_new;
            if (tap_hit) capture <= scaled;
            if (seq_err || last_row) hit <= 1'b0;
            else if (tap_hit)        hit <= 1'b1;
            if (seq_err) begin
                expected_row <= 6'd0;
                if (seq_err_count != 16'hFFFF) seq_err_count <= seq_err_count + 16'd1;
            end else if (in_seq) begin
                expected_row <= last_row ? 6'd0 : bus.node_row + 6'd1;
            end
        end
    end

    // A full FIFO still accepts a push when the consumer frees the head slot in the same cycle.
    assign pop     = (fifo_level != 5'd0) && bus.sample_ready;
    assign full    = (fifo_level == DEPTH);
    assign do_push = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= 5'd0;
            last_data      <= 16'd0;
            overflow_count <= 16'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_data <= mem[rd_ptr];
            end
            case ({do_push, pop})
                2'b10:   fifo_level <= fifo_level + 5'd1;
                2'b01:   fifo_level <= fifo_level - 5'd1;
                default: fifo_level <= fifo_level;
            endcase
            if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        end
    end

    assign bus.sample_valid = (fifo_level != 5'd0);
    assign bus.sample_data  = bus.sample_valid ? mem[rd_ptr] : last_data;
endmodule

// File: tb/tb_drum_sample_tap.sv
// Scoreboard bench for drum_sample_tap: stimulus queues expected samples,
// a negedge monitor pops and compares every accepted sample.
module tb_drum_sample_tap;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  tap_row;
    logic [2:0]  gain_shift;
    logic        step_done;
    logic [4:0]  fifo_level;
    logic [15:0] overflow_count;
    logic [15:0] seq_err_count;

    int          checks = 0;
    int          errors = 0;
    int          step_pulses = 0;
    int          pulses_before;
    logic [15:0] exp_q [$];
    logic [15:0] exp_val;
    logic [17:0] amp_val;

    drum_sample_tap_if bus ();

    drum_sample_tap dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .tap_row        (tap_row),
        .gain_shift     (gain_shift),
        .step_done      (step_done),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count),
        .seq_err_count  (seq_err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] row, input logic [17:0] amp);
        bus.node_valid = 1'b1;
        bus.node_row   = row;
        bus.node_amp   = amp;
        @(posedge clk);
        #1;
        bus.node_valid = 1'b0;
    endtask

    task automatic send_rows(input int first, input int last, input int tap, input logic [17:0] tap_amp);
        for (int r = first; r <= last; r++)
            applyStimulus(6'(r), (r == tap) ? tap_amp : 18'(r * 32'h400));
    endtask

    task automatic send_step(input int tap, input logic [17:0] tap_amp);
        send_rows(0, 32, tap, tap_amp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bus.sample_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        checkOutput({name, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    // Monitor: every accepted sample must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && step_done) step_pulses++;
        if (!rst && bus.sample_valid && bus.sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_sample: got 0x%0h, expected no sample", bus.sample_data);
            end else begin
                checkOutput("sample_data", 32'(bus.sample_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus.node_valid   = 1'b0;
        bus.node_row     = 6'd0;
        bus.node_amp     = 18'd0;
        bus.sample_ready = 1'b1;
        tap_row          = 6'd16;
        gain_shift       = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(bus.sample_valid), 32'd0);
        checkOutput("rst_data", 32'(bus.sample_data), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_step_done", 32'(step_done), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_count), 32'd0);
        checkOutput("rst_seq_err", 32'(seq_err_count), 32'd0);
        rst = 1'b0;
        idle(1);

        // Three clean steps, tap 16, amplitude row*0x400.
        pulses_before = step_pulses;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(16'h1000);
            send_step(16, 18'h04000);
            checkOutput("clean_step_done", 32'(step_done), 32'd1);
            checkOutput("clean_valid_latency", 32'(bus.sample_valid), 32'd1);
            idle(2);
        end
        checkOutput("clean_step_pulses", 32'(step_pulses - pulses_before), 32'd3);
        drain("clean");

        // Consumer stalled for six steps: four kept, two dropped.
        tap_row          = 6'd8;
        bus.sample_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_q.push_back(16'h0800);
            send_step(8, 18'h02000);
        end
        checkOutput("stall_level", 32'(fifo_level), 32'd4);
        checkOutput("stall_overflow", 32'(overflow_count), 32'd2);
        checkOutput("stall_valid", 32'(bus.sample_valid), 32'd1);
        drain("stall");

        // Row 10 skipped: step abandoned, next full step pushes.
        bus.sample_ready = 1'b0;
        send_rows(0, 9, 8, 18'h02000);
        applyStimulus(6'd11, 18'(11 * 32'h400));
        idle(1);
        checkOutput("seqerr_count", 32'(seq_err_count), 32'd1);
        checkOutput("seqerr_no_push", 32'(fifo_level), 32'd0);
        exp_q.push_back(16'h0800);
        send_step(8, 18'h02000);
        checkOutput("seqerr_recover_done", 32'(step_done), 32'd1);
        checkOutput("seqerr_recover_level", 32'(fifo_level), 32'd1);
        drain("seqerr");

        // Gain 4 saturates both directions.
        tap_row    = 6'd16;
        gain_shift = 3'd4;
        exp_q.push_back(16'h7FFF);
        send_step(16, 18'h04000);
        exp_q.push_back(16'h8000);
        send_step(16, 18'h3C000);
        gain_shift = 3'd0;
        drain("gain");

        // Out-of-range tap falls back to row 16; full FIFO with simultaneous pop.
        tap_row          = 6'd40;
        bus.sample_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_val = 16'h2000 + 16'(k * 32'h1000);
            amp_val = 18'h08000 + 18'(k * 32'h4000);
            exp_q.push_back(exp_val);
            send_step(16, amp_val);
        end
        checkOutput("deftap_full_level", 32'(fifo_level), 32'd4);
        exp_q.push_back(16'h6000);
        send_rows(0, 31, 16, 18'h18000);
        bus.sample_ready = 1'b1;
        applyStimulus(6'd32, 18'h08000);
        bus.sample_ready = 1'b0;
        checkOutput("pushpop_level", 32'(fifo_level), 32'd4);
        checkOutput("pushpop_overflow", 32'(overflow_count), 32'd2);
        drain("deftap");

        // Reset in the middle of a step with two samples queued.
        tap_row          = 6'd16;
        bus.sample_ready = 1'b0;
        send_step(16, 18'h04000);
        send_step(16, 18'h04000);
        checkOutput("prereset_level", 32'(fifo_level), 32'd2);
        send_rows(0, 19, 16, 18'h04000);
        rst = 1'b1;
        applyStimulus(6'd20, 18'(20 * 32'h400));
        rst = 1'b0;
        checkOutput("midrst_valid", 32'(bus.sample_valid), 32'd0);
        checkOutput("midrst_data", 32'(bus.sample_data), 32'd0);
        checkOutput("midrst_level", 32'(fifo_level), 32'd0);
        checkOutput("midrst_step_done", 32'(step_done), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow_count), 32'd0);
        checkOutput("midrst_seq_err", 32'(seq_err_count), 32'd0);
        send_rows(21, 32, 16, 18'h04000);
        checkOutput("resume_ignored_done", 32'(step_done), 32'd0);
        checkOutput("resume_ignored_level", 32'(fifo_level), 32'd0);
        checkOutput("resume_ignored_seq_err", 32'(seq_err_count), 32'd0);
        bus.sample_ready = 1'b1;
        exp_q.push_back(16'h1000);
        send_step(16, 18'h04000);
        checkOutput("resume_step_done", 32'(step_done), 32'd1);
        drain("resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
